// File: rtl/grid_scan_controller.sv
// Walks an X_DIM x Y_DIM grid one cell at a time.
// Each cell is offered to the datapath together with cyclic prev/next
// neighbour indices on both axes. The scan advances on step_ready and
// pulses done once the last cell has been consumed.
//
// state | meaning
// IDLE  | waiting for start; mode is latched on the accepting edge
// INIT  | counters cleared, one cycle
// CAL   | cell (x_cur, y_cur) is valid; advance on step_ready
// DONE  | one-cycle done pulse, then back to IDLE
module grid_scan_controller #(
  parameter int X_DIM = 5,
  parameter int Y_DIM = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             step_ready,
  output logic             busy,
  output logic             cell_valid,
  output logic             last_cell,
  output logic             done,
  output logic [IDX_W-1:0] x_prev,
  output logic [IDX_W-1:0] x_cur,
  output logic [IDX_W-1:0] x_next,
  output logic [IDX_W-1:0] y_prev,
  output logic [IDX_W-1:0] y_cur,
  output logic [IDX_W-1:0] y_next
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_CAL  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] X_MAX = IDX_W'(X_DIM - 1);
  localparam logic [IDX_W-1:0] Y_MAX = IDX_W'(Y_DIM - 1);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] x_q, x_d;
  logic [IDX_W-1:0] y_q, y_d;
  logic             mode_q, mode_d;
  logic             x_at_max, y_at_max;

  assign x_at_max = (x_q == X_MAX);
  assign y_at_max = (y_q == Y_MAX);

  // Next-state and counter stepping; the inner axis is selected by the latched mode.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          mode_d  = mode;
        end
      end
      S_INIT: begin
        x_d     = '0;
        y_d     = '0;
        state_d = S_CAL;
      end
      S_CAL: begin
        if (step_ready) begin
          if (x_at_max && y_at_max) begin
            x_d     = '0;
            y_d     = '0;
            state_d = S_DONE;
          end else if (!mode_q) begin
            if (y_at_max) begin
              y_d = '0;
              x_d = x_q + ONE;
            end else begin
              y_d = y_q + ONE;
            end
          end else begin
            if (x_at_max) begin
              x_d = '0;
              y_d = y_q + ONE;
            end else begin
              x_d = x_q + ONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters and mode latch; reset aborts any scan in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign cell_valid = (state_q == S_CAL);
  assign last_cell  = cell_valid && x_at_max && y_at_max;
  assign done       = (state_q == S_DONE);

  assign x_cur  = x_q;
  assign y_cur  = y_q;
  assign x_prev = (x_q == '0) ? X_MAX : (x_q - ONE);
  assign x_next = x_at_max ? '0 : (x_q + ONE);
  assign y_prev = (y_q == '0) ? Y_MAX : (y_q - ONE);
  assign y_next = y_at_max ? '0 : (y_q + ONE);

endmodule

// File: tb/tb_grid_scan_controller.sv
// Bench for grid_scan_controller: a 5x5 instance (A) and a 4x3 instance (B)
// share their inputs; one of them is observed per run.
module tb_grid_scan_controller;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, mode, step_ready;

  logic       a_busy, a_valid, a_last, a_done;
  logic [2:0] a_xp, a_xc, a_xn, a_yp, a_yc, a_yn;
  logic       b_busy, b_valid, b_last, b_done;
  logic [1:0] b_xp, b_xc, b_xn, b_yp, b_yc, b_yn;

  grid_scan_controller #(.X_DIM(5), .Y_DIM(5), .IDX_W(3)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step_ready(step_ready),
    .busy(a_busy), .cell_valid(a_valid), .last_cell(a_last), .done(a_done),
    .x_prev(a_xp), .x_cur(a_xc), .x_next(a_xn),
    .y_prev(a_yp), .y_cur(a_yc), .y_next(a_yn)
  );

  grid_scan_controller #(.X_DIM(4), .Y_DIM(3), .IDX_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step_ready(step_ready),
    .busy(b_busy), .cell_valid(b_valid), .last_cell(b_last), .done(b_done),
    .x_prev(b_xp), .x_cur(b_xc), .x_next(b_xn),
    .y_prev(b_yp), .y_cur(b_yc), .y_next(b_yn)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int run; int k;
    int valid; int last; int done; int busy;
    int x; int y; int xp; int xn; int yp; int yn;
  } vec_t;

  vec_t tbl[$];

  int r_valid[64], r_last[64], r_done[64], r_busy[64];
  int r_x[64], r_y[64], r_xp[64], r_xn[64], r_yp[64], r_yn[64];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int run, input int k, input int valid, input int last,
                     input int dn, input int busy, input int x, input int y,
                     input int xp, input int xn, input int yp, input int yn);
    vec_t v;
    v.run = run; v.k = k; v.valid = valid; v.last = last; v.done = dn; v.busy = busy;
    v.x = x; v.y = y; v.xp = xp; v.xn = xn; v.yp = yp; v.yn = yn;
    tbl.push_back(v);
  endtask

  task automatic sample(input int sel, input int k);
    if (sel == 0) begin
      r_valid[k] = int'(a_valid); r_last[k] = int'(a_last);
      r_done[k]  = int'(a_done);  r_busy[k] = int'(a_busy);
      r_x[k]  = int'(a_xc); r_y[k]  = int'(a_yc);
      r_xp[k] = int'(a_xp); r_xn[k] = int'(a_xn);
      r_yp[k] = int'(a_yp); r_yn[k] = int'(a_yn);
    end else begin
      r_valid[k] = int'(b_valid); r_last[k] = int'(b_last);
      r_done[k]  = int'(b_done);  r_busy[k] = int'(b_busy);
      r_x[k]  = int'(b_xc); r_y[k]  = int'(b_yc);
      r_xp[k] = int'(b_xp); r_xn[k] = int'(b_xn);
      r_yp[k] = int'(b_yp); r_yn[k] = int'(b_yn);
    end
  endtask

  task automatic apply_table(input int run);
    foreach (tbl[i]) begin
      if (tbl[i].run == run) begin
        int k;
        k = tbl[i].k;
        chk($sformatf("r%0d k%0d valid", run, k), r_valid[k], tbl[i].valid);
        chk($sformatf("r%0d k%0d last", run, k), r_last[k], tbl[i].last);
        chk($sformatf("r%0d k%0d done", run, k), r_done[k], tbl[i].done);
        chk($sformatf("r%0d k%0d busy", run, k), r_busy[k], tbl[i].busy);
        if (tbl[i].x >= 0) begin
          chk($sformatf("r%0d k%0d x_cur", run, k), r_x[k], tbl[i].x);
          chk($sformatf("r%0d k%0d y_cur", run, k), r_y[k], tbl[i].y);
          chk($sformatf("r%0d k%0d x_prev", run, k), r_xp[k], tbl[i].xp);
          chk($sformatf("r%0d k%0d x_next", run, k), r_xn[k], tbl[i].xn);
          chk($sformatf("r%0d k%0d y_prev", run, k), r_yp[k], tbl[i].yp);
          chk($sformatf("r%0d k%0d y_next", run, k), r_yn[k], tbl[i].yn);
        end
      end
    end
  endtask

  // k counts negedges after the start-accepting edge E, so sample k is cycle E+k.
  task automatic run(input int id, input int sel, input bit m, input int sx, input int sy,
                     input int slen, input bit toggle, input bit extra, input bit hold,
                     input int exp_done, input int exp_nvalid);
    int nx, ny, n, idx, scnt, done_k, nvalid, nlast, nd, ex, ey, xc, yc;
    bit v;
    nx = (sel != 0) ? 4 : 5;
    ny = (sel != 0) ? 3 : 5;
    n = nx * ny;
    idx = 0; scnt = 0; done_k = -1; nvalid = 0; nlast = 0; nd = 0;
    @(negedge clk);
    start = 1'b1; mode = m; step_ready = 1'b1;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      sample(sel, k);
      v = (r_valid[k] != 0);
      xc = r_x[k]; yc = r_y[k];
      if (r_done[k] != 0) begin
        nd++;
        if (done_k < 0) done_k = k;
        idx = 0;
      end
      if (v) begin
        nvalid++;
        if (r_last[k] != 0) nlast++;
        ex = m ? (idx % nx) : (idx / ny);
        ey = m ? (idx / nx) : (idx % ny);
        chk($sformatf("r%0d k%0d order x", id, k), xc, ex);
        chk($sformatf("r%0d k%0d order y", id, k), yc, ey);
        chk($sformatf("r%0d k%0d last_cell", id, k), r_last[k], int'(idx == n - 1));
      end
      start = hold && (k < 29);
      if (extra && v && xc == 1 && yc == 1) start = 1'b1;
      if (extra && r_done[k] != 0) start = 1'b1;
      if (toggle && (k == 5 || k == 12)) mode = ~mode;
      if (v && xc == sx && yc == sy && scnt < slen) begin
        step_ready = 1'b0;
        scnt++;
      end else begin
        step_ready = 1'b1;
      end
      if (v && step_ready) idx++;
    end
    start = 1'b0;
    step_ready = 1'b1;
    chk($sformatf("r%0d done cycle", id), done_k, exp_done);
    chk($sformatf("r%0d done pulses", id), nd, 1);
    chk($sformatf("r%0d last_cell count", id), nlast, 1);
    if (exp_nvalid >= 0) chk($sformatf("r%0d cell_valid cycles", id), nvalid, exp_nvalid);
    apply_table(id);
  endtask

  task automatic wait_idle();
    int t;
    start = 1'b0;
    t = 0;
    while ((a_busy || b_busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("wait idle timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int found, bad;
    // run 0: A mode 0
    add(0, 1, 0, 0, 0, 1, 0, 0, 4, 1, 4, 1);
    add(0, 2, 1, 0, 0, 1, 0, 0, 4, 1, 4, 1);
    add(0, 3, 1, 0, 0, 1, 0, 1, 4, 1, 0, 2);
    add(0, 7, 1, 0, 0, 1, 1, 0, 0, 2, 4, 1);
    add(0, 26, 1, 1, 0, 1, 4, 4, 3, 0, 3, 0);
    add(0, 27, 0, 0, 1, 1, 0, 0, 4, 1, 4, 1);
    add(0, 28, 0, 0, 0, 0, 0, 0, 4, 1, 4, 1);
    // run 1: A mode 1 with mode toggled mid-scan
    add(1, 3, 1, 0, 0, 1, 1, 0, 0, 2, 4, 1);
    add(1, 7, 1, 0, 0, 1, 0, 1, 4, 1, 0, 2);
    add(1, 27, 0, 0, 1, 1, 0, 0, 4, 1, 4, 1);
    // run 2: stall three cycles at (2,3)
    add(2, 15, 1, 0, 0, 1, 2, 3, 1, 3, 2, 4);
    add(2, 16, 1, 0, 0, 1, 2, 3, 1, 3, 2, 4);
    add(2, 17, 1, 0, 0, 1, 2, 3, 1, 3, 2, 4);
    add(2, 18, 1, 0, 0, 1, 2, 3, 1, 3, 2, 4);
    add(2, 19, 1, 0, 0, 1, 2, 4, 1, 3, 3, 0);
    add(2, 30, 0, 0, 1, 1, 0, 0, 4, 1, 4, 1);
    // run 3: stray starts ignored
    add(3, 28, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
    add(3, 35, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1);
    // run 4: B (4x3, IDX_W=2)
    add(4, 1, 0, 0, 0, 1, 0, 0, 3, 1, 2, 1);
    add(4, 2, 1, 0, 0, 1, 0, 0, 3, 1, 2, 1);
    add(4, 13, 1, 1, 0, 1, 3, 2, 2, 0, 1, 0);
    add(4, 14, 0, 0, 1, 1, 0, 0, 3, 1, 2, 1);
    add(4, 15, 0, 0, 0, 0, 0, 0, 3, 1, 2, 1);
    // run 5: start held high relaunches after one IDLE cycle
    add(5, 28, 0, 0, 0, 0, 0, 0, 4, 1, 4, 1);
    add(5, 29, 0, 0, 0, 1, 0, 0, 4, 1, 4, 1);
    add(5, 30, 1, 0, 0, 1, 0, 0, 4, 1, 4, 1);

    rst = 1'b0; start = 1'b0; mode = 1'b0; step_ready = 1'b1;
    #12;
    chk("reset busy", int'(a_busy), 0);
    chk("reset cell_valid", int'(a_valid), 0);
    chk("reset last_cell", int'(a_last), 0);
    chk("reset done", int'(a_done), 0);
    chk("reset x_cur", int'(a_xc), 0);
    chk("reset y_cur", int'(a_yc), 0);
    chk("reset x_prev", int'(a_xp), 4);
    chk("reset x_next", int'(a_xn), 1);
    chk("reset y_prev", int'(a_yp), 4);
    chk("reset B x_prev", int'(b_xp), 3);
    chk("reset B y_prev", int'(b_yp), 2);
    @(negedge clk);
    rst = 1'b1;

    run(0, 0, 1'b0, -1, -1, 0, 1'b0, 1'b0, 1'b0, 27, 25);
    wait_idle();
    run(1, 0, 1'b1, -1, -1, 0, 1'b1, 1'b0, 1'b0, 27, 25);
    wait_idle();
    run(2, 0, 1'b0, 2, 3, 3, 1'b0, 1'b0, 1'b0, 30, 28);
    wait_idle();
    run(3, 0, 1'b0, -1, -1, 0, 1'b0, 1'b1, 1'b0, 27, 25);
    wait_idle();
    run(4, 1, 1'b0, -1, -1, 0, 1'b0, 1'b0, 1'b0, 14, 12);
    wait_idle();
    run(5, 0, 1'b0, -1, -1, 0, 1'b0, 1'b0, 1'b1, 27, -1);
    wait_idle();

    // asynchronous reset in the middle of a scan
    @(negedge clk);
    start = 1'b1; mode = 1'b0; step_ready = 1'b1;
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (a_valid && a_xc == 3'd3 && a_yc == 3'd1) found = 1;
    end
    chk("reach cell (3,1)", found, 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst busy", int'(a_busy), 0);
    chk("async rst cell_valid", int'(a_valid), 0);
    chk("async rst done", int'(a_done), 0);
    chk("async rst x_cur", int'(a_xc), 0);
    chk("async rst y_cur", int'(a_yc), 0);
    chk("async rst x_prev", int'(a_xp), 4);
    chk("async rst y_next", int'(a_yn), 1);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      if (a_done || a_busy) bad++;
    end
    chk("post reset quiet cycles", bad, 0);
    run(6, 0, 1'b0, -1, -1, 0, 1'b0, 1'b0, 1'b0, 27, 25);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/grid_scan_controller.md
Name: grid_scan_controller

Overview:
- Parametrised scan controller for 2-D lane/state arrays (X_DIM x Y_DIM cells).
- Walks every (x,y) cell exactly once per run, in either y-inner (column) or x-inner (row) order.
- For each cell, presents cyclic prev/cur/next indices on both axes to a neighbour-accessing datapath (parity, theta-like steps).
- Handshakes per cell with the datapath through step_ready, and pulses done when the scan completes.

Parameters:
- X_DIM, 5, number of x positions; must satisfy 2 <= X_DIM <= 2^IDX_W.
- Y_DIM, 5, number of y positions; must satisfy 2 <= Y_DIM <= 2^IDX_W.
- IDX_W, 3, width of every index output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; sampled only in IDLE.
- mode  in  1  scan order: 0 = y inner / x outer; 1 = x inner / y outer. Latched when start is accepted.
- step_ready  in  1  datapath has consumed the current cell; the scan advances only when this is high in CAL.
- busy  out  1  high in INIT, CAL and DONE.
- cell_valid  out  1  high in CAL; indices are valid for the datapath.
- last_cell  out  1  high in CAL when the current cell is the final cell of the scan.
- done  out  1  one-cycle pulse in DONE.
- x_prev, x_cur, x_next  out  IDX_W  cyclic x indices.
- y_prev, y_cur, y_next  out  IDX_W  cyclic y indices.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, x_cur=0, y_cur=0, mode latch=0.
  - busy, cell_valid, last_cell and done are 0.
  - Index outputs show x_cur/y_cur=0, prev=DIM-1, next=1.
  - Reset asserted mid-scan aborts the scan immediately; no done pulse is produced.
- Index derivation (combinational from the registered x_cur/y_cur):
  - prev = (cur==0) ? DIM-1 : cur-1.
  - next = (cur==DIM-1) ? 0 : cur+1.
- State machine (registered):
  - IDLE: if start=1, go to INIT and latch mode. Otherwise stay in IDLE.
  - INIT: clear x_cur and y_cur to 0; go to CAL. Lasts 1 cycle.
  - CAL: cell_valid=1.
    - If step_ready=0: hold state and indices (stall).
    - If step_ready=1 and the current cell is not last: advance the inner counter. When the inner counter wraps DIM-1 -> 0, advance the outer counter in the same edge.
    - If step_ready=1 and last_cell=1: go to DONE. Both counters wrap to 0 on this edge.
  - DONE: done=1 for 1 cycle; go to IDLE.
- last_cell definition: cell_valid & (x_cur==X_DIM-1) & (y_cur==Y_DIM-1).
- Scan order:
  - mode 0: (0,0),(0,1)...(0,Y-1),(1,0)...
  - mode 1: (0,0),(1,0)...(X-1,0),(0,1)...
- Timing, with start accepted at edge E and step_ready tied high:
  - INIT occupies cycle E+1.
  - CAL occupies cycles E+2 .. E+1+X_DIM*Y_DIM.
  - done is high in cycle E+2+X_DIM*Y_DIM.
  - Each low cycle of step_ready adds one cycle.
- Boundary rules:
  - start while busy is ignored; no restart and no mode change.
  - start held high continuously relaunches from IDLE the cycle after DONE (one IDLE cycle between runs).
  - mode changes while busy have no effect.
  - Counters never leave the range 0..DIM-1.

Test Plan:
- Defaults, mode=0, step_ready=1, start pulse at edge E:
  - required cell sequence is (x,y)=(0,0),(0,1),(0,2),(0,3),(0,4),(1,0)... (4,4);
  - 25 cell_valid cycles, last_cell only on (4,4), done at cycle E+27;
  - at (0,0): x_prev=4, x_next=1; at (4,4): x_next=0, y_next=0.
- mode=1, defaults: order is (0,0),(1,0)...(4,0),(0,1); done at E+27; mode toggled mid-scan has no effect on the order.
- Stall: drop step_ready for 3 cycles at cell (2,3). Indices must stay at (2,3) with cell_valid=1 for those 3 cycles; done is delayed to E+30.
- X_DIM=4, Y_DIM=3, IDX_W=2, mode=0:
  - 12 cells; at (3,2): x_next=0, y_next=0, last_cell=1;
  - at (0,0): y_prev=2, x_prev=3; done at E+14.
- start pulses during CAL at (1,1) and during DONE are ignored: the scan completes normally, then the bench returns to IDLE with busy=0.
- rst driven low asynchronously (between clock edges) at cell (3,1):
  - busy, cell_valid and done fall to 0 immediately, indices return to 0, no done pulse;
  - after release, a new start yields a full 25-cell scan from (0,0).
